// File: rtl/instruction_fetcher.sv
// Sequential instruction fetcher: walks the instruction memory from address 0.
// Each byte goes to the decoder over valid/ready until the terminator or the end of memory.
module instruction_fetcher #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_DEPTH      = 128,
  parameter logic [DATA_WIDTH-1:0] END_OF_PROGRAM = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] instr_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t                state_reg,  state_next;
  logic [ADDR_WIDTH-1:0] pc_reg,     pc_next;
  logic [DATA_WIDTH-1:0] instr_reg,  instr_next;
  logic [ADDR_WIDTH-1:0] count_reg,  count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      instr_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
          count_next = '0;
        end
      end
      FETCH: begin
        // The terminator itself is never presented downstream.
        if (mem_data == END_OF_PROGRAM) begin
          state_next = DONE;
        end else begin
          instr_next = mem_data;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          count_next = count_reg + 1'b1;
          // Stop at the last word rather than letting pc wrap past the memory.
          if (pc_reg == LAST_ADDR) begin
            state_next = ERROR;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // All outputs decode from registered state only; no path from start/instr_ready.
  assign mem_enable  = (state_reg == FETCH);
  assign mem_address = (state_reg == IDLE) ? '0 : pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = (state_reg == HOLD);
  assign busy        = (state_reg == FETCH) || (state_reg == HOLD);
  assign done        = (state_reg == DONE);
  assign error       = (state_reg == ERROR);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher: a list-walk model of the program fills the
// expected queue, and a negedge monitor pops it on every handshake.
module tb_instruction_fetcher;
  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       instr_ready = 1'b0;
  logic [7:0] mem_address, mem_data, instr, instr_count;
  logic       mem_enable, instr_valid, busy, done, error;

  logic [7:0] mem [DEPTH];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = -10;
  int last_xfer = -1;
  int stall_cnt = 0;
  bit first_term = 1'b0;
  bit hold_prev = 1'b0;
  logic [7:0] held = 8'h00;
  int ready_mode = 0;
  int stall_left = 0;
  int exp_count = 0;
  bit exp_done = 1'b0;
  bit exp_error = 1'b0;

  instruction_fetcher dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_address (mem_address),
    .mem_enable  (mem_enable),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Memory read port; a floating bus reads back as a recognisable junk value.
  assign mem_data = (mem_enable && mem_address < 8'(DEPTH)) ? mem[mem_address[6:0]] : 8'hA5;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer: always ready, random ready, or a 5-cycle stall on instruction 3.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: instr_ready = 1'b1;
      1: instr_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (instr_valid && instr == 8'd3 && stall_left > 0) begin
          instr_ready = 1'b0;
          stall_left--;
        end else begin
          instr_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: one line per accepted instruction, checks against the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (start && !busy) begin
        start_cyc  = cyc;
        first_term = (mem[0] == 8'hFF);
        last_xfer  = -1;
        stall_cnt  = 0;
      end
      if (cyc == start_cyc + 1)
        chk("start_fetch", int'({busy, mem_enable, done, error}), 4'b1100);
      if (cyc == start_cyc + 2) begin
        chk("first_valid", int'(instr_valid), int'(!first_term));
        chk("first_done", int'(done), int'(first_term));
      end
      if (mem_enable) begin
        chk("addr_range", int'(mem_address < 8'(DEPTH)), 1);
        chk("en_only_fetch", int'(busy && !instr_valid), 1);
      end
      if (instr_valid) begin
        chk("hold_en_low", int'(mem_enable), 0);
        chk("valid_expected", int'(exp_q.size() > 0), 1);
      end
      if (hold_prev)
        chk("hold_stable", int'({instr_valid, instr}), int'({1'b1, held}));
      if (instr_valid && instr_ready) begin
        if (exp_q.size() > 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("xfer addr=%0d instr=%0d expected=%0d", mem_address, instr, e);
          chk("instr", int'(instr), int'(e));
        end
        if (last_xfer >= 0)
          chk("xfer_gap", cyc - last_xfer, 2 + stall_cnt);
        last_xfer = cyc;
        stall_cnt = 0;
      end else if (instr_valid) begin
        stall_cnt++;
      end
      hold_prev = instr_valid && !instr_ready;
      held      = instr;
    end
  end

  // Reference model: the program is every byte from address 0 up to the first
  // terminator; with no terminator all DEPTH bytes are delivered and error results.
  task automatic begin_run();
    exp_q.delete();
    exp_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] == 8'hFF) begin
        exp_done = 1'b1;
        break;
      end
      exp_q.push_back(mem[i]);
    end
    exp_count = exp_q.size();
    exp_error = !exp_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_run();
    int n = 0;
    while (!(done || error) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("run_timeout", int'(n < 3000), 1);
    @(negedge clk);
    chk("done", int'(done), int'(exp_done));
    chk("error", int'(error), int'(exp_error));
    chk("count", int'(instr_count), exp_count);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_end", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 chk("end_en_low", int'(mem_enable), 0);
  endtask

  task automatic wait_instr(input logic [7:0] v);
    int n = 0;
    while (!(instr_valid && instr == v) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_instr_timeout", int'(n < 500), 1);
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h77;
    mem[0] = 8'd4; mem[1] = 8'd3; mem[2] = 8'd8; mem[3] = 8'd5; mem[4] = 8'hFF;
  endtask

  initial begin
    logic [7:0] cnt0, addr0;
    load_prog();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({mem_address, mem_enable, instr, instr_valid, busy, done,
                              error, instr_count}), 0);
    reset = 1'b0;

    // Basic program, always ready, then a restart straight from DONE
    ready_mode = 0;
    begin_run();
    finish_run();
    begin_run();
    finish_run();

    // Backpressure on instruction 3, with an ignored start pulse during HOLD
    ready_mode = 2;
    stall_left = 5;
    begin_run();
    wait_instr(8'd3);
    cnt0  = instr_count;
    addr0 = mem_address;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("hold_start_count", int'(instr_count), int'(cnt0));
    chk("hold_start_pc", int'(mem_address), int'(addr0));
    chk("hold_start_valid", int'(instr_valid), 1);
    finish_run();

    // Terminator at address 0
    ready_mode = 0;
    mem[0] = 8'hFF;
    begin_run();
    finish_run();

    // No terminator: full memory then error
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h01;
    begin_run();
    finish_run();

    // Asynchronous reset while holding instruction 8, then a clean refetch
    load_prog();
    begin_run();
    wait_instr(8'd8);
    #1 reset = 1'b1;
    #1 chk("async_reset", int'({mem_address, mem_enable, instr, instr_valid, busy, done,
                                error, instr_count}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    begin_run();
    finish_run();

    // Random programs with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 254));
      if ($urandom_range(0, 3) != 0) mem[$urandom_range(0, DEPTH - 1)] = 8'hFF;
      begin_run();
      finish_run();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Sequential reader for the 128-byte instruction memory. On `start` it walks the memory from address 0, presents each byte to the downstream decoder over a valid/ready handshake, and stops on the END_OF_PROGRAM byte (8'hFF). The memory's combinational read port (address, enable, data) is driven from this block. This is the only master of that port.

## Interface
- `ADDR_WIDTH`, 8: memory address width.
- `DATA_WIDTH`, 8: instruction width.
- `MEM_DEPTH`, 128: number of memory words. Must be ≤ 2^ADDR_WIDTH.
- `END_OF_PROGRAM`, 8'hFF: terminator byte.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a program fetch. Honoured only in IDLE, DONE or ERROR.
- `mem_address`  out  ADDR_WIDTH  memory read address.
- `mem_enable`  out  1  memory read enable.
- `mem_data`  in  DATA_WIDTH  memory read data. Combinational: valid in the same cycle as `mem_address`/`mem_enable`.
- `instr`  out  DATA_WIDTH  fetched instruction.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  consumer accepts `instr`.
- `busy`  out  1  high in FETCH or HOLD.
- `done`  out  1  level; END_OF_PROGRAM was reached.
- `error`  out  1  level; the end of memory was reached without a terminator.
- `instr_count`  out  ADDR_WIDTH  number of instructions handshaken since the last `start`.

## Operation
- States: IDLE, FETCH, HOLD, DONE, ERROR. The state is encoded in registers. All outputs are decoded from the state or taken from registers.
- Registers: `pc` (ADDR_WIDTH), `instr` (DATA_WIDTH), `instr_count` (ADDR_WIDTH).
- IDLE:
  - `mem_enable`=0, `mem_address`=0.
  - On `start`: `pc`←0, `instr_count`←0, go to FETCH.
- FETCH:
  - `mem_enable`=1, `mem_address`=`pc`.
  - At the edge, if `mem_data`==END_OF_PROGRAM: go to DONE. `instr` is not updated.
  - Otherwise: `instr`←`mem_data`, go to HOLD.
- HOLD:
  - `mem_enable`=0, `mem_address`=`pc` (held). `instr_valid`=1 and `instr` is stable.
  - At the edge with `instr_ready`=1:
    - `instr_count`+1.
    - If `pc`==MEM_DEPTH-1, go to ERROR.
    - Otherwise `pc`←`pc`+1 and go to FETCH.
  - With `instr_ready`=0: stay in HOLD. Nothing changes.
- DONE / ERROR:
  - `mem_enable`=0. `done` or `error` stays high.
  - `pc` and `instr_count` are held.
  - `start` restarts exactly as from IDLE: in the next cycle `done`/`error` drop and the state goes to FETCH.
- `start` is ignored in FETCH and HOLD.
- `instr_ready` outside HOLD has no effect.
- `mem_enable` is high only in FETCH. The memory's tri-state data bus therefore floats in every other state.

## Timing
- Reset (asynchronous, immediate, including mid-fetch): state IDLE.
  - `pc`, `instr`, `instr_count`, `mem_address` = 0.
  - `mem_enable`, `instr_valid`, `busy`, `done`, `error` = 0.
- `start` sampled high at edge N: FETCH during cycle N+1.
  - First `instr_valid` in cycle N+2.
  - A terminator at address 0 instead gives `done`=1 in cycle N+2.
- Throughput: at most one instruction every 2 cycles (FETCH + HOLD). There is one extra cycle per backpressured cycle.
- Transfer happens on the edge where `instr_valid` and `instr_ready` are both 1. `instr_valid` drops in the following cycle (FETCH).
- `instr_count` updates on the same edge as the transfer.
- Maximum `instr_count` is MEM_DEPTH (128), which fits in 8 bits. The count does not wrap.
- There is no combinational path from `instr_ready` or `start` to any output.

## Test plan
- Program 4,3,8,5,FF; `instr_ready` tied 1; `start` pulse:
  - `instr` sequence 4,3,8,5, each valid for 1 cycle, 2 cycles apart.
  - `done`=1, `instr_count`=4.
  - `mem_enable` is never high after DONE.
- Same program, `instr_ready` low for 5 cycles while `instr`=3 is valid:
  - `instr` holds 3, `instr_valid` stays 1 and `mem_enable` stays 0 for those cycles.
  - Sequence then resumes with 8.
- mem[0]=FF: `start`, then `done`=1 two cycles later. `instr_valid` is never high and `instr_count`=0.
- Memory filled with 8'h01, no terminator, ready=1:
  - 128 transfers, then `error`=1 and `instr_count`=128.
  - `mem_address` never exceeds 127.
- `reset` asserted while in HOLD with `instr`=8:
  - All outputs go to 0 immediately (asynchronously).
  - A following `start` re-fetches from address 0 and yields 4 first.
- `start` pulsed during HOLD: ignored (`pc` and `instr_count` unchanged).
- `start` in DONE: a clean refetch of 4,3,8,5, with `done` low in the meantime.
